// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master drives a request; the slave (the arithmetic block) reports progress and results.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice plus a registered carry,
// walking WIDTH-bit operands LSB first over WIDTH/DIGIT clocks.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_accept;
  logic             w_lastStep;

  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_count;

  logic [DIGIT:0]   w_sum;
  logic             w_carryMsb;
  logic [PW-1:0]    w_bitPos;
  logic [WIDTH-1:0] w_sNext;

  // The slice sum bit XOR its operand bits recovers the carry into the digit's top bit.
  assign w_sum      = {1'b0, r_opA[DIGIT-1:0]} + {1'b0, r_opB[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_carryMsb = w_sum[DIGIT-1] ^ r_opA[DIGIT-1] ^ r_opB[DIGIT-1];
  assign w_bitPos   = PW'(r_count) * PW'(DIGIT);
  assign w_sNext    = r_s | (WIDTH'(w_sum[DIGIT-1:0]) << w_bitPos);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_lastStep  = (r_count == CW'(STEPS - 1));
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (w_lastStep) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = RUN;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the operand inversion and forced carry happen at load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_opA   <= bus.a;
      r_opB   <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_s     <= '0;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_s     <= w_sNext;
      r_carry <= w_sum[DIGIT];
      r_opA   <= r_opA >> DIGIT;
      r_opB   <= r_opB >> DIGIT;
      r_count <= r_count + CW'(1);
      if (w_lastStep) begin
        r_cout <= w_sum[DIGIT];
        r_ovf  <= w_sum[DIGIT] ^ w_carryMsb;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
